// File: rtl/neuron_driver.sv
// Ready/valid front end for a fixed-latency ReLU neuron: input FIFO, credit-based issue, result FIFO.
// Define NEURON_DRV_SELFCHECK_EN to add a shadow model that flags mismatching neuron outputs on err.
module neuron_driver #(
  parameter int unsigned IDEPTH  = 4,
  parameter int unsigned RDEPTH  = 4,
  parameter int unsigned LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic signed [7:0]  ld_x,
  input  logic signed [7:0]  ld_w,
  input  logic signed [7:0]  ld_bias,
  output logic signed [7:0]  n_x,
  output logic signed [7:0]  n_w,
  output logic signed [7:0]  n_bias,
  input  logic signed [17:0] n_y,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [17:0] res_data,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int unsigned IAW = $clog2(IDEPTH);
  localparam int unsigned RAW = $clog2(RDEPTH);
  localparam int unsigned CW  = $clog2(RDEPTH + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;
  state_e state_q;

  logic [23:0]        in_mem [IDEPTH];
  logic [IAW:0]       in_wptr_q, in_rptr_q;
  logic [23:0]        in_head;
  logic               in_empty, in_full, ld_fire;
  logic [17:0]        res_mem [RDEPTH];
  logic [RAW:0]       res_wptr_q, res_rptr_q;
  logic               res_empty, res_pop;
  logic [CW-1:0]      credits_q;
  logic [LATENCY-1:0] vld_q;
  logic               issue, capture;

  assign in_empty  = (in_wptr_q == in_rptr_q);
  assign in_full   = (in_wptr_q[IAW] != in_rptr_q[IAW]) &&
                     (in_wptr_q[IAW-1:0] == in_rptr_q[IAW-1:0]);
  // Held low while reset is asserted even though the FIFO is empty.
  assign ld_ready  = rst_n & ~in_full;
  assign ld_fire   = ld_valid & ld_ready;
  assign in_head   = in_mem[in_rptr_q[IAW-1:0]];

  assign res_empty = (res_wptr_q == res_rptr_q);
  assign res_valid = ~res_empty;
  assign res_data  = res_empty ? '0 : res_mem[res_rptr_q[RAW-1:0]];
  assign res_pop   = res_valid & res_ready;

  // Credits cover both stored and in-flight results, so a capture always finds space.
  assign issue   = (state_q == StIssue) & ~in_empty & (credits_q < CW'(RDEPTH));
  assign capture = vld_q[LATENCY-1];

  always_ff @(posedge clk) begin
    if (ld_fire) in_mem[in_wptr_q[IAW-1:0]] <= {ld_x, ld_w, ld_bias};
    if (capture) res_mem[res_wptr_q[RAW-1:0]] <= n_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_wptr_q  <= '0;
      in_rptr_q  <= '0;
      res_wptr_q <= '0;
      res_rptr_q <= '0;
      credits_q  <= '0;
      vld_q      <= '0;
      n_x        <= '0;
      n_w        <= '0;
      n_bias     <= '0;
    end else begin
      if (ld_fire) in_wptr_q  <= in_wptr_q + 1'b1;
      if (issue)   in_rptr_q  <= in_rptr_q + 1'b1;
      if (capture) res_wptr_q <= res_wptr_q + 1'b1;
      if (res_pop) res_rptr_q <= res_rptr_q + 1'b1;
      credits_q <= credits_q + CW'(issue) - CW'(res_pop);
      vld_q     <= (vld_q << 1) | LATENCY'(issue);
      if (issue) begin
        n_x    <= in_head[23:16];
        n_w    <= in_head[15:8];
        n_bias <= in_head[7:0];
      end else begin
        n_x    <= '0;
        n_w    <= '0;
        n_bias <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q <= StIssue;
            busy    <= 1'b1;
          end
        end
        StIssue: begin
          if (!run) state_q <= StDrain;
        end
        StDrain: begin
          if (run) begin
            state_q <= StIssue;
          end else if (vld_q == '0) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef NEURON_DRV_SELFCHECK_EN
  logic signed [7:0]  hx, hw, hb;
  logic signed [15:0] prod;
  logic signed [16:0] sum;
  logic [17:0]        exp_now;
  logic [17:0]        exp_q [LATENCY];

  always_comb begin
    hx      = in_head[23:16];
    hw      = in_head[15:8];
    hb      = in_head[7:0];
    prod    = hx * hw;
    sum     = {prod[15], prod} + {{9{hb[7]}}, hb};
    exp_now = sum[16] ? 18'd0 : {1'b0, sum};
  end

  // Expected values ride alongside vld_q; only entries with a valid bit are ever compared.
  always_ff @(posedge clk) begin
    exp_q[0] <= exp_now;
    for (int i = 1; i < int'(LATENCY); i++) exp_q[i] <= exp_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else if (capture && (n_y != exp_q[LATENCY-1])) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_driver.sv
// Scoreboard bench for neuron_driver with a behavioural neuron model on the n_* / n_y side.
module tb_neuron_driver;
  localparam int unsigned IDEPTH  = 4;
  localparam int unsigned RDEPTH  = 4;
  localparam int unsigned LATENCY = 3;
`ifdef NEURON_DRV_SELFCHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, ld_valid = 1'b0, res_ready = 1'b0;
  logic signed [7:0]  ld_x = '0, ld_w = '0, ld_bias = '0;
  logic signed [7:0]  n_x, n_w, n_bias;
  logic signed [17:0] n_y, res_data;
  logic               ld_ready, res_valid, busy, done, err;

  int tests = 0, fails = 0, cyc = 0, issue_cnt = 0;
  logic signed [17:0] sb[$];
  int                 pop_times[$];
  logic signed [17:0] exp_v;
  logic               bad_mode = 1'b0;
  logic signed [17:0] y_pipe [LATENCY-1];

  neuron_driver #(.IDEPTH(IDEPTH), .RDEPTH(RDEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_x(ld_x), .ld_w(ld_w), .ld_bias(ld_bias), .n_x(n_x), .n_w(n_w), .n_bias(n_bias),
    .n_y(n_y), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [17:0] relu_ref(input logic signed [7:0] x, w, b);
    int s;
    s = int'(x) * int'(w) + int'(b);
    return (s < 0) ? 18'sd0 : 18'(s);
  endfunction

  // Neuron model: n_* sampled at the edge after issue, n_y ready for capture LATENCY edges after issue.
  always @(posedge clk) begin
    if (bad_mode && n_x == 8'sd3 && n_w == 8'sd2 && n_bias == 8'sd1) y_pipe[0] <= 18'sd5;
    else y_pipe[0] <= relu_ref(n_x, n_w, n_bias);
    for (int i = 1; i < int'(LATENCY) - 1; i++) y_pipe[i] <= y_pipe[i-1];
  end
  assign n_y = y_pipe[LATENCY-2];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      pop_times.push_back(cyc);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %0d required none", res_data);
      end else begin
        exp_v = sb.pop_front();
        check("result_data", int'(res_data), int'(exp_v));
      end
    end
    if (rst_n && (n_x != 0 || n_w != 0 || n_bias != 0)) issue_cnt++;
  end

  task automatic load(input logic signed [7:0] x, w, b, input bit keep, input int exp);
    int n;
    n = 0;
    ld_valid = 1'b1; ld_x = x; ld_w = w; ld_bias = b;
    @(negedge clk);
    while (!ld_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ld_ready) begin
      tests++;
      fails++;
      $display("FAIL load_timeout: ld_ready got 0 required 1");
      ld_valid = 1'b0;
      return;
    end
    if (keep) sb.push_back(18'(exp));
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, sb.size(), 0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, base, dcnt, seen, err_before, err_rise;
    #12;
    check("rst_n_x", int'(n_x), 0);
    check("rst_n_w", int'(n_w), 0);
    check("rst_n_bias", int'(n_bias), 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ld_ready", ld_ready, 1);
    res_ready = 1'b1;
    run = 1'b1;
    @(posedge clk);
    #1;

    // Single triple: latency and one-cycle operand presentation.
    load(3, 2, 1, 1, 7);
    k = 0;
    while (k < 10) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k == 1) begin
        check("t1_n_x", int'(n_x), 3);
        check("t1_n_w", int'(n_w), 2);
        check("t1_n_bias", int'(n_bias), 1);
      end
      if (k == 2) check("t1_n_x_cleared", int'(n_x), 0);
      if (res_valid) break;
    end
    check("t1_latency", k, LATENCY + 1);
    wait_empty("t1");

    // Back-to-back stream, including negative clamp and the extreme product.
    pop_times.delete();
    load(10, 10, -5, 1, 95);
    load(-5, 5, 4, 1, 0);
    load(100, 1, -128, 1, 0);
    load(-128, -128, 127, 1, 16511);
    wait_empty("t2");
    check("t2_err", err, 0);
    check("t2_pops", pop_times.size(), 4);
    if (pop_times.size() >= 4) check("t2_consecutive", pop_times[3] - pop_times[0], 3);

    // Consumer stalled: credits cap issue at RDEPTH, input FIFO fills, then all drain in order.
    res_ready = 1'b0;
    base = issue_cnt;
    load(1, 2, 3, 1, 5);
    load(2, 3, -4, 1, 2);
    load(-3, 4, 5, 1, 0);
    load(4, -5, 6, 1, 0);
    load(5, 6, -7, 1, 23);
    load(-6, -7, 8, 1, 50);
    load(7, 8, 9, 1, 65);
    load(8, -9, 10, 1, 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t3_issued_stalled", issue_cnt - base, RDEPTH);
    check("t3_ld_ready_full", ld_ready, 0);
    check("t3_res_valid", res_valid, 1);
    check("t3_head", int'(res_data), 5);
    res_ready = 1'b1;
    wait_empty("t3");
    repeat (3) @(posedge clk);
    #1;
    check("t3_issued_total", issue_cnt - base, 8);

    // Drain: two issued, run dropped, the rest stay queued.
    run = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t4_idle_busy", busy, 0);
    base = issue_cnt;
    load(1, 1, 1, 1, 2);
    load(2, 2, 2, 1, 6);
    load(3, 3, 3, 0, 0);
    load(4, 4, 4, 0, 0);
    run = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    run = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        check("t4_busy_with_done", busy, 0);
      end
    end
    check("t4_done_pulses", dcnt, 1);
    check("t4_issued", issue_cnt - base, 2);
    check("t4_results_out", sb.size(), 0);
    check("t4_busy_end", busy, 0);

    // Reset with the two leftover triples in flight.
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    check("t5_n_x", int'(n_x), 0);
    check("t5_n_w", int'(n_w), 0);
    check("t5_res_valid", res_valid, 0);
    check("t5_ld_ready", ld_ready, 0);
    check("t5_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * int'(LATENCY); i++) begin
      @(negedge clk);
      if (res_valid) seen = 1;
    end
    check("t5_no_result_after_reset", seen, 0);

    // Faulty neuron output: err behaviour depends on the self-check build.
    run = 1'b1;
    bad_mode = 1'b1;
    @(posedge clk);
    #1;
    load(3, 2, 1, 1, 5);
    k = 0;
    err_before = 0;
    err_rise = 0;
    while (k < 10) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (res_valid) begin
        err_rise = err;
        break;
      end
      err_before = err;
    end
    check("t6_err_before_capture", err_before, 0);
    check("t6_err_at_capture", err_rise, EXP_ERR);
    wait_empty("t6");
    repeat (5) @(negedge clk);
    check("t6_err_sticky", err, EXP_ERR);
    bad_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/neuron_driver.md
Name: neuron_driver

Overview:
- Master-side companion to the single-input neuron (y = ReLU(x*w + bias), 18-bit signed result, fixed pipeline latency).
- Accepts operand triples over a ready/valid load port and buffers them in an input FIFO.
- Drives the triples into the neuron one per cycle, captures the neuron output exactly LATENCY cycles later, and returns results in order over a ready/valid result port.
- Credit-based issue, so no result is ever dropped.

Parameters:
- IDEPTH, 4, input FIFO depth in triples; power of two, >= 2.
- RDEPTH, 4, result FIFO depth in words; power of two, >= 2.
- LATENCY, 3, rising edges from n_x/n_w/n_bias driven to n_y valid; >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = issue enabled, 1->0 = drain and stop.
- ld_valid  in  1  load triple valid.
- ld_ready  out  1  input FIFO not full.
- ld_x  in  8  signed activation.
- ld_w  in  8  signed weight.
- ld_bias  in  8  signed bias.
- n_x  out  8  signed, to neuron x.
- n_w  out  8  signed, to neuron w.
- n_bias  out  8  signed, to neuron bias.
- n_y  in  18  signed, from neuron y.
- res_valid  out  1  result FIFO not empty.
- res_ready  in  1  consumer accepts result.
- res_data  out  18  signed result, head of result FIFO.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on DRAIN->IDLE.
- err  out  1  sticky self-check mismatch (see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - FIFOs empty, delay line cleared, credits 0, state IDLE.
  - n_x = n_w = n_bias = 0; res_valid = 0; res_data = 0; ld_ready = 0 during reset, 1 after; busy = done = err = 0.
- Load: transfer when ld_valid & ld_ready; the triple is written at that edge. ld_ready = !in_full, combinational from registered count.
- Result: pop when res_valid & res_ready. res_data is the registered FIFO head, stable while res_valid & !res_ready.
- Credits = result FIFO occupancy + in-flight count; always <= RDEPTH.
- issue = (state == ISSUE) & !in_empty & (credits < RDEPTH).
  - On issue: the popped triple is registered onto n_x/n_w/n_bias at that edge and a valid bit enters a LATENCY-deep shift register.
  - Cycles without issue: n_x/n_w/n_bias = 0, valid bit 0.
- Capture: when the shift-register output bit is 1, n_y is written into the result FIFO on that edge. Latency is exactly LATENCY edges from the n_* update. Back-to-back issue gives one result per cycle.
- Same-cycle issue, capture and pop:
  - credits' = credits + issue - pop.
  - Capture moves one credit from in-flight to occupancy (net 0).
  - A pop frees a credit usable in the next cycle, not the same cycle.
- Simultaneous load and issue on a full input FIFO: load is refused because ld_ready = 0.
- FSM:
  - IDLE -> ISSUE when run = 1.
  - ISSUE -> DRAIN when run = 0.
  - DRAIN: no new issue. Transition to IDLE when in-flight == 0 (the result FIFO may still hold data). done pulses on that edge.
  - Unissued triples remain in the input FIFO.
  - DRAIN -> ISSUE if run returns to 1 before in-flight reaches 0.
- Pointer wrap: pointers carry one extra bit; full/empty by MSB compare. No loss or duplication across wrap.
- Reset mid-operation: all in-flight and buffered data discarded. The neuron's own pipeline results arriving after reset release are ignored because the valid bits are cleared.

Optional Feature:
- Macro: NEURON_DRV_SELFCHECK_EN.
- Defined:
  - A LATENCY-deep shadow pipeline computes expected = (x*w sign-extended to 17 bits + bias sign-extended) → 18 bits, then 0 if negative.
  - Each captured n_y is compared against it; on mismatch err sets at the capture edge and stays set until reset.
  - The result is still stored unchanged.
- Not defined: no shadow logic; err tied to 0.

Test Plan:
- run = 1, load (3,2,1) → n_x = 3, n_w = 2, n_bias = 1 for one cycle; res_data = 7, res_valid rises LATENCY+1 edges after the load edge.
- Load (10,10,-5), (-5,5,4), (100,1,-128), (-128,-128,127) back-to-back → results 95, 0, 0, 16511 in order on consecutive cycles; err = 0.
- res_ready = 0, load 8 triples → exactly RDEPTH issued; ld_ready falls after IDEPTH buffered. Then res_ready = 1 → all 8 results in order, none lost or duplicated (covers pointer wrap).
- 2 triples issued, run dropped next cycle → DRAIN; done pulses once both are captured; busy falls with done; remaining queued triples are not issued.
- rst_n asserted while 2 results are in flight → outputs zero immediately; after release res_valid stays 0 for 2*LATENCY cycles.
- With NEURON_DRV_SELFCHECK_EN defined, bench neuron model forces n_y = 5 for (3,2,1) → err = 1 at that capture edge and stays 1; without the macro err = 0.
